uart_cmd_wrapper: RTL
=====================

# uart_cmd_wrapper

Knight-side endpoint of the remote command link: the counterpart to the remote command transmitter. Receives 8N1 UART bytes on RX, assembles each high/low byte pair into a 16-bit command for the command processor, and serializes the 8-bit response byte (e.g. 0xA5 positive ack) back on TX. Sits between the board RX/TX pins and the command-processing FSM inside the Knight top level.

## Interface
Parameters
- BAUD_DIV, 2604: clk cycles per bit (50 MHz / 19200 baud); must be ≥ 4.

Ports
- clk  in  1  system clock
- rst  in  1  reset: one clock, synchronous, active-high
- RX  in  1  serial in, idle high, asynchronous to clk
- TX  out  1  serial out, idle high
- cmd  out  16  last complete command, {first byte, second byte}
- cmd_rdy  out  1  level: new command available
- clr_cmd_rdy  in  1  pulse: consumer has taken cmd
- resp  in  8  response byte to send
- trmt  in  1  pulse: start sending resp
- tx_done  out  1  level: last response fully sent

## Operation
- Reset values: TX=1, cmd=0, cmd_rdy=0, tx_done=0; RX synchronizer flops=1; both FSMs idle; assembler expects high byte.
- RX path: two-flop synchronizer on RX; start is a synced falling edge while idle. Load baud counter with BAUD_DIV/2 and sample mid-start, then every BAUD_DIV for 8 data bits (LSB first) plus stop bit. Byte complete on stop-bit sample; stop value not checked. Start sample of 1 = glitch, return to idle, no byte.
- RX FSM states: IDLE, RECV. IDLE→RECV on start edge; RECV→IDLE after stop sample.
- Assembler states: HIGH, LOW. Byte in HIGH: store in hi register, go LOW. Byte in LOW: cmd <= {hi, byte}, cmd_rdy <= 1, go HIGH.
- cmd_rdy clears on clr_cmd_rdy or on the start edge of a new high byte. cmd holds its value until the next complete pair.
- Simultaneous clr_cmd_rdy and pair completion: set wins, cmd_rdy stays 1.
- TX path: trmt while idle loads {1, resp, 0}, clears tx_done, enters TRANSMIT. Shift LSB-first each BAUD_DIV cycles for 10 bits. After the stop bit: back to IDLE, tx_done <= 1. trmt while transmitting is ignored; resp is sampled only on an accepted trmt.
- RX and TX are fully independent; full duplex.
- rst mid-frame: both paths abort immediately, TX forced high, partial high byte discarded.

## Timing
- Start edge is detected 2–3 cycles after the RX pin falls (synchronizer).
- Byte complete ≈ BAUD_DIV/2 + 9·BAUD_DIV cycles after start detect. cmd/cmd_rdy update the cycle after the low-byte stop sample.
- TX falls the cycle after an accepted trmt. Each bit is exactly BAUD_DIV cycles. tx_done rises 10·BAUD_DIV cycles after TX falls, together with the return to idle.
- tx_done and cmd_rdy are levels, not pulses.

## Structure
- Shared package (knight_pkg): BAUD_DIV default constant, the positive-ack (8'hA5) and negative-ack constants, rx_state_t/tx_state_t/asm_state_t enums.
- One natural sub-module: uart_core (rx + tx shift/baud logic, ports rx_data/rx_rdy, tx_data/trmt/tx_done). uart_cmd_wrapper adds the byte-pair assembler and the cmd_rdy set/clear logic.

## Test plan
- Reset: assert rst for 2 cycles → TX=1, cmd=0, cmd_rdy=0, tx_done=0. Hold RX high 20 bit times → no cmd_rdy.
- Command receive: drive 16'h2000 (calibrate) through the remote transmitter model → cmd=16'h2000, cmd_rdy=1 ≈ 19.5·BAUD_DIV cycles after first start edge. Repeat with 16'h4BF1 → cmd=16'h4BF1.
- Clear rules: pulse clr_cmd_rdy → cmd_rdy=0 next cycle, cmd unchanged. Repeat with clr_cmd_rdy on the completion cycle → cmd_rdy=1. New high byte start edge → cmd_rdy falls.
- Response: trmt with resp=8'hA5 → remote model resp_rdy with resp=8'hA5. Check TX waveform 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV spacing; tx_done=1 at 10·BAUD_DIV. Second trmt mid-frame with resp=8'h5A → ignored, A5 frame intact.
- Full duplex/glitch: receive a command while transmitting → both correct. A 1-cycle RX low pulse → no byte, assembler stays in HIGH.
- Reset mid-operation: rst after the high byte 8'h20 and mid-TX → TX=1 immediately. Next pair 8'h40,8'h00 → cmd=16'h4000 (no stale 8'h20).

Source files
------------

// File: rtl/knight_pkg.sv
// Shared constants and state types for the Knight remote command link.
package knight_pkg;

   localparam int unsigned BAUD_DIV_DEFAULT = 2604;   // 50 MHz / 19200 baud
   localparam logic [7:0]  POS_ACK          = 8'hA5;
   localparam logic [7:0]  NEG_ACK          = 8'hEE;

   typedef enum logic {RX_IDLE, RX_RECV}     rx_state_t;
   typedef enum logic {TX_IDLE, TX_TRANSMIT} tx_state_t;
   typedef enum logic {ASM_HIGH, ASM_LOW}    asm_state_t;

endpackage

// File: rtl/uart_core.sv
// 8N1 UART core: independent receiver and transmitter sharing only the clock.
module uart_core
   import knight_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   output logic       TX,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       rx_start,
   input  logic [7:0] tx_data,
   input  logic       trmt,
   output logic       tx_done
);

   localparam int unsigned CW      = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);

   // ---------------- receiver ----------------
   logic            r_rx_sync1, r_rx_sync2, r_rx_sync3;
   rx_state_t       r_rx_state, w_rx_state_nxt;
   logic [CW-1:0]   r_rx_cnt;
   logic [3:0]      r_rx_bit;
   logic [7:0]      r_rx_shift;
   logic            r_rx_rdy;
   logic            w_rx_start, w_rx_tick;

   assign w_rx_start = (r_rx_state == RX_IDLE) && r_rx_sync3 && !r_rx_sync2;
   assign w_rx_tick  = (r_rx_state == RX_RECV) && (r_rx_cnt == '0);

   // RX pin synchronizer plus one delay stage for falling-edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_sync1 <= 1'b1;
         r_rx_sync2 <= 1'b1;
         r_rx_sync3 <= 1'b1;
      end else begin
         r_rx_sync1 <= RX;
         r_rx_sync2 <= r_rx_sync1;
         r_rx_sync3 <= r_rx_sync2;
      end
   end

   // RX state register
   always_ff @(posedge clk) begin
      if (rst) r_rx_state <= RX_IDLE;
      else     r_rx_state <= w_rx_state_nxt;
   end

   // RX next state: a high start sample is a glitch, stop sample ends the frame
   always_comb begin
      w_rx_state_nxt = r_rx_state;
      case (r_rx_state)
         RX_IDLE: if (w_rx_start) w_rx_state_nxt = RX_RECV;
         RX_RECV: if (w_rx_tick && (((r_rx_bit == 4'd0) && r_rx_sync2) || (r_rx_bit == 4'd9)))
                     w_rx_state_nxt = RX_IDLE;
         default: w_rx_state_nxt = RX_IDLE;
      endcase
   end

   // RX baud counter, bit index and LSB-first shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rx_rdy   <= 1'b0;
      end else begin
         r_rx_rdy <= 1'b0;
         if (w_rx_start) begin
            r_rx_cnt <= HALF_LD;
            r_rx_bit <= '0;
         end else if (r_rx_state == RX_RECV) begin
            if (r_rx_cnt == '0) begin
               r_rx_cnt <= FULL_LD;
               r_rx_bit <= r_rx_bit + 4'd1;
               if ((r_rx_bit >= 4'd1) && (r_rx_bit <= 4'd8))
                  r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
               if (r_rx_bit == 4'd9)
                  r_rx_rdy <= 1'b1;
            end else begin
               r_rx_cnt <= r_rx_cnt - 1'b1;
            end
         end
      end
   end

   assign rx_data  = r_rx_shift;
   assign rx_rdy   = r_rx_rdy;
   assign rx_start = w_rx_start;

   // ---------------- transmitter ----------------
   tx_state_t       r_tx_state, w_tx_state_nxt;
   logic [8:0]      r_tx_shift;   // {stop, data}; start bit goes straight to r_tx
   logic [CW-1:0]   r_tx_cnt;
   logic [3:0]      r_tx_bit;
   logic            r_tx;
   logic            r_tx_done;
   logic            w_tx_load, w_tx_tick, w_tx_last;

   assign w_tx_load = (r_tx_state == TX_IDLE) && trmt;
   assign w_tx_tick = (r_tx_state == TX_TRANSMIT) && (r_tx_cnt == '0);
   assign w_tx_last = w_tx_tick && (r_tx_bit == 4'd9);

   // TX state register
   always_ff @(posedge clk) begin
      if (rst) r_tx_state <= TX_IDLE;
      else     r_tx_state <= w_tx_state_nxt;
   end

   // TX next state: trmt only accepted while idle
   always_comb begin
      w_tx_state_nxt = r_tx_state;
      case (r_tx_state)
         TX_IDLE:     if (trmt)      w_tx_state_nxt = TX_TRANSMIT;
         TX_TRANSMIT: if (w_tx_last) w_tx_state_nxt = TX_IDLE;
         default:                    w_tx_state_nxt = TX_IDLE;
      endcase
   end

   // TX shifter with registered line output so TX never glitches
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_shift <= '1;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx       <= 1'b1;
         r_tx_done  <= 1'b0;
      end else if (w_tx_load) begin
         r_tx_shift <= {1'b1, tx_data};
         r_tx_cnt   <= FULL_LD;
         r_tx_bit   <= '0;
         r_tx       <= 1'b0;
         r_tx_done  <= 1'b0;
      end else if (r_tx_state == TX_TRANSMIT) begin
         if (r_tx_cnt == '0) begin
            r_tx_cnt <= FULL_LD;
            if (r_tx_bit == 4'd9) begin
               r_tx      <= 1'b1;
               r_tx_done <= 1'b1;
            end else begin
               r_tx       <= r_tx_shift[0];
               r_tx_shift <= {1'b1, r_tx_shift[8:1]};
               r_tx_bit   <= r_tx_bit + 4'd1;
            end
         end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
         end
      end
   end

   assign TX      = r_tx;
   assign tx_done = r_tx_done;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Knight-side command endpoint: pairs received bytes into 16-bit commands.
module uart_cmd_wrapper
   import knight_pkg::*;
#(
   parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        trmt,
   output logic        tx_done
);

   logic [7:0]  w_rx_data;
   logic        w_rx_rdy, w_rx_start;
   logic        w_pair_done, w_hi_start;
   asm_state_t  r_asm_state, w_asm_nxt;
   logic [7:0]  r_hi;
   logic [15:0] r_cmd;
   logic        r_cmd_rdy;

   uart_core #(.BAUD_DIV(BAUD_DIV)) u_core (
      .clk      (clk),
      .rst      (rst),
      .RX       (RX),
      .TX       (TX),
      .rx_data  (w_rx_data),
      .rx_rdy   (w_rx_rdy),
      .rx_start (w_rx_start),
      .tx_data  (resp),
      .trmt     (trmt),
      .tx_done  (tx_done)
   );

   assign w_pair_done = w_rx_rdy && (r_asm_state == ASM_LOW);
   assign w_hi_start  = w_rx_start && (r_asm_state == ASM_HIGH);

   // Assembler state register
   always_ff @(posedge clk) begin
      if (rst) r_asm_state <= ASM_HIGH;
      else     r_asm_state <= w_asm_nxt;
   end

   // Assembler next state: alternate on every completed byte
   always_comb begin
      w_asm_nxt = r_asm_state;
      if (w_rx_rdy)
         w_asm_nxt = (r_asm_state == ASM_HIGH) ? ASM_LOW : ASM_HIGH;
   end

   // High-byte hold, command register and cmd_rdy (set beats clear)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi      <= '0;
         r_cmd     <= '0;
         r_cmd_rdy <= 1'b0;
      end else begin
         if (w_rx_rdy && (r_asm_state == ASM_HIGH))
            r_hi <= w_rx_data;
         if (w_pair_done)
            r_cmd <= {r_hi, w_rx_data};
         if (w_pair_done)
            r_cmd_rdy <= 1'b1;
         else if (clr_cmd_rdy || w_hi_start)
            r_cmd_rdy <= 1'b0;
      end
   end

   assign cmd     = r_cmd;
   assign cmd_rdy = r_cmd_rdy;

endmodule
